qbert_cube_tracker: RTL
=======================

Name: qbert_cube_tracker

Overview:
- Tracks which of the 28 pyramid cubes Q*bert has coloured, and detects level completion.
- Sits downstream of the map/colour renderer: consumes its one-hot cube occupancy vector `position_qb` and the landing strobe `done_move`.
- Produces the 28-bit cube colour vector that feeds back into the renderer's `e_color_state` input.
- Also provides a cube count, landing-event flags and a level-done interrupt for the NIOS.

Parameters:
- N_CUBE, 28, number of cubes in the pyramid; width of `position_qb` and `color_state`.
- CNT_W, 5, width of the coloured-cube counter; must satisfy 2^CNT_W > N_CUBE.

Ports:
- CLK_33  input  1  pixel/system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- e_start_qb  input  1  NIOS start; IDLE->PLAY
- e_clear  input  1  NIOS synchronous clear of board and counter
- done_move  input  1  level from Q*bert layer, high when a jump has finished
- position_qb  input  N_CUBE  one-hot cube under Q*bert (bit 0 = top cube, 27 = bottom-right)
- color_state  output  N_CUBE  1 = cube top coloured; drives `e_color_state`
- cube_count  output  CNT_W  number of coloured cubes
- land_ok  output  1  one-cycle pulse: valid landing processed
- off_map  output  1  one-cycle pulse: landing with no cube under Q*bert
- pos_err  output  1  sticky: landing with more than one occupancy bit set
- level_done  output  1  high while in DONE state (NIOS interrupt line)
- tracker_state  output  2  00 IDLE, 01 PLAY, 10 DONE

Behaviour:
- Reset values (asynchronous):
  - `color_state` = 0, `cube_count` = 0.
  - `land_ok`, `off_map`, `pos_err`, `level_done` = 0.
  - `tracker_state` = IDLE.
  - Edge-detect register = 0.
- Landing event:
  - Rising edge of `done_move` (sampled high this cycle, low the previous cycle).
  - `position_qb` is captured into a register in the same cycle the edge is detected.
- Latency:
  - Edge detected at clock k; `color_state`, `cube_count` and the pulse outputs update at clock k+1.
  - Pulses last exactly one cycle.
- Landing events are processed only in PLAY; in IDLE and DONE they are ignored and no flags fire.
- Decoding the captured vector P:
  - Exactly one bit set: set that bit in `color_state`.
    - If the bit was previously 0, increment `cube_count`.
    - If already 1, no change.
    - Pulse `land_ok` in either case.
  - P = 0: pulse `off_map`; board unchanged.
  - Two or more bits set: set `pos_err` (sticky until clear/reset); board unchanged; no pulses.
- One-hot check: P != 0 and (P & (P-1)) == 0, computed at N_CUBE width.
- State machine:
  - IDLE -> PLAY on `e_start_qb`.
  - PLAY -> DONE in the same clock that `cube_count` becomes N_CUBE; `level_done` is asserted that clock.
  - DONE holds until `e_clear`.
  - Any state -> IDLE on `e_clear`.
- `e_clear` clears `color_state`, `cube_count`, `pos_err` and the captured vector.
- Simultaneous events:
  - `e_clear` beats a landing event and beats `e_start_qb`.
  - `e_start_qb` in PLAY or DONE is ignored.
  - A landing edge in the same cycle as `e_start_qb` from IDLE is ignored.
- Held inputs:
  - `done_move` held high for many cycles counts as one event.
  - A new event needs `done_move` low for at least one cycle.
- `cube_count` saturates at N_CUBE and never wraps.
- Reset mid-event discards any captured position.

Optional Feature:
- Macro: QBERT_TOGGLE_MODE_EN.
- When defined (advanced-level rules): a valid landing on an already coloured cube clears its bit and decrements `cube_count`, saturating at 0. `land_ok` still pulses.
- When undefined: colouring is sticky as described above.
- DONE entry is unchanged in both modes.

Test Plan:
- Reset, `e_start_qb`, landing with `position_qb` = 0x0000001 -> next clock: `color_state` = 0x0000001, `cube_count` = 1, `land_ok` pulse, `tracker_state` = 01.
- Second landing on bit 0 -> `cube_count` stays 1, `land_ok` pulses.
  - With QBERT_TOGGLE_MODE_EN: `color_state` = 0, `cube_count` = 0.
- Landing with `position_qb` = 0 -> `off_map` pulses once, board unchanged. Landing with 0x0000006 -> `pos_err` = 1 and stays high, board unchanged.
- 28 distinct one-hot landings -> `cube_count` = 28, `level_done` = 1 and `tracker_state` = 10 on the 28th update. A 29th landing is ignored.
- `done_move` held high for 50 cycles -> exactly one update. In IDLE, a landing with 0x0000010 -> no change.
- `e_clear` asserted in the same cycle as a landing edge -> `color_state` = 0, `cube_count` = 0, `tracker_state` = 00, no pulses. Asynchronous `reset` mid-PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/qbert_cube_tracker.sv
// Tracks coloured pyramid cubes from Q*bert landings and flags level completion.
// Optional macro QBERT_TOGGLE_MODE_EN: landing on a coloured cube uncolours it.
module qbert_cube_tracker #(
    parameter int N_CUBE = 28,
    parameter int CNT_W  = 5
) (
    input  logic              CLK_33,
    input  logic              reset,
    input  logic              e_start_qb,
    input  logic              e_clear,
    input  logic              done_move,
    input  logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] color_state,
    output logic [CNT_W-1:0]  cube_count,
    output logic              land_ok,
    output logic              off_map,
    output logic              pos_err,
    output logic              level_done,
    output logic [1:0]        tracker_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_CUBE);

    state_t            state;
    logic              done_prev;
    logic              cap_valid;
    logic [N_CUBE-1:0] cap_pos;

    logic land_edge;
    logic cap_onehot;
    logic cap_hit;

    assign land_edge     = done_move & ~done_prev;
    assign cap_onehot    = (cap_pos != '0) && ((cap_pos & (cap_pos - N_CUBE'(1))) == '0);
    assign cap_hit       = |(color_state & cap_pos);
    assign tracker_state = state;

    // Landing captured on the rising edge of done_move, decoded one clock later.
    always_ff @(posedge CLK_33 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            done_prev   <= 1'b0;
            cap_valid   <= 1'b0;
            cap_pos     <= '0;
            color_state <= '0;
            cube_count  <= '0;
            land_ok     <= 1'b0;
            off_map     <= 1'b0;
            pos_err     <= 1'b0;
            level_done  <= 1'b0;
        end else begin
            done_prev <= done_move;
            land_ok   <= 1'b0;
            off_map   <= 1'b0;
            if (e_clear) begin
                state       <= IDLE;
                cap_valid   <= 1'b0;
                cap_pos     <= '0;
                color_state <= '0;
                cube_count  <= '0;
                pos_err     <= 1'b0;
                level_done  <= 1'b0;
            end else begin
                cap_valid <= 1'b0;
                case (state)
                    IDLE: begin
                        if (e_start_qb) begin
                            state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (land_edge) begin
                            cap_pos   <= position_qb;
                            cap_valid <= 1'b1;
                        end
                        if (cap_valid) begin
                            if (cap_onehot) begin
                                land_ok <= 1'b1;
`ifdef QBERT_TOGGLE_MODE_EN
                                if (cap_hit) begin
                                    color_state <= color_state & ~cap_pos;
                                    if (cube_count != '0) begin
                                        cube_count <= cube_count - CNT_W'(1);
                                    end
                                end else begin
                                    color_state <= color_state | cap_pos;
                                    if (cube_count != FULL) begin
                                        cube_count <= cube_count + CNT_W'(1);
                                    end
                                    if (cube_count == FULL - CNT_W'(1)) begin
                                        state      <= DONE;
                                        level_done <= 1'b1;
                                    end
                                end
`else
                                color_state <= color_state | cap_pos;
                                if (!cap_hit && cube_count != FULL) begin
                                    cube_count <= cube_count + CNT_W'(1);
                                    if (cube_count == FULL - CNT_W'(1)) begin
                                        state      <= DONE;
                                        level_done <= 1'b1;
                                    end
                                end
`endif
                            end else if (cap_pos == '0) begin
                                off_map <= 1'b1;
                            end else begin
                                pos_err <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        level_done <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
